// File: rtl/s_out_stream_unit.sv
`default_nettype none
// ============================================================================
//  Module   : s_out_stream_unit
//  Purpose  : PEA output-stream stage. Captures the selected PE result into a
//             small FIFO, streams it out on valid/ready and stalls the PEA
//             when the FIFO is full. S_OUT_STREAM_LAST_EN adds length-bounded
//             streams with last/done signalling.
//  Revision : 1.0 - initial release
// ============================================================================
module s_out_stream_unit #(
    parameter int N_BITS   = 32,
    parameter int N_PE_SRC = 4,
    parameter int DEPTH    = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         en_i,
    input  logic                         flush_i,
    input  logic [$clog2(N_PE_SRC)-1:0]  sel_i,
    input  logic [N_PE_SRC*N_BITS-1:0]   pe_res_i,
    input  logic [N_PE_SRC-1:0]          pe_valid_i,
    output logic                         pea_ready_o,
    output logic [N_BITS-1:0]            stream_data_o,
    output logic                         stream_valid_o,
    input  logic                         stream_ready_i
`ifdef S_OUT_STREAM_LAST_EN
    ,
    input  logic [15:0]                  len_i,
    output logic                         last_o,
    output logic                         done_o
`endif
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH + 1);
`ifdef S_OUT_STREAM_LAST_EN
    localparam int c_ent_w = N_BITS + 1;
`else
    localparam int c_ent_w = N_BITS;
`endif

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
`ifdef S_OUT_STREAM_LAST_EN
    localparam logic [1:0] c_st_done = 2'd2;
`endif

    localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(DEPTH);

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [c_ent_w-1:0]  r_mem [DEPTH];
    logic [c_ptr_w-1:0]  r_wr_ptr;
    logic [c_ptr_w-1:0]  r_rd_ptr;
    logic [c_ptr_w-1:0]  w_rd_ptr_inc;
    logic [c_cnt_w-1:0]  r_count;
    logic [c_ent_w-1:0]  r_head;
    logic [c_ent_w-1:0]  w_entry;
    logic [N_BITS-1:0]   w_sel_data;
    logic                w_full;
    logic                w_push;
    logic                w_pop;

    assign w_sel_data     = pe_res_i[int'(sel_i)*N_BITS +: N_BITS];
    assign w_full         = (r_count == c_full);
    assign pea_ready_o    = (r_state != c_st_run) | ~w_full;
    assign w_push         = (r_state == c_st_run) & pea_ready_o & pe_valid_i[sel_i];
    assign stream_valid_o = (r_count != '0);
    assign w_pop          = stream_valid_o & stream_ready_i;
    assign w_rd_ptr_inc   = r_rd_ptr + c_ptr_w'(1);
    assign stream_data_o  = r_head[N_BITS-1:0];

`ifdef S_OUT_STREAM_LAST_EN
    logic [15:0] r_push_cnt;
    logic        r_done;
    logic        w_push_last;

    // The element whose push makes the running count equal len_i is the last one.
    assign w_push_last = (len_i != 16'd0) &&
                         (({1'b0, r_push_cnt} + 17'd1) == {1'b0, len_i});
    assign w_entry     = {w_push_last, w_sel_data};
    assign last_o      = r_head[N_BITS] & stream_valid_o;
    assign done_o      = r_done;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_push_cnt <= 16'd0;
            r_done     <= 1'b0;
        end else if (flush_i) begin
            r_push_cnt <= 16'd0;
            r_done     <= 1'b0;
        end else begin
            if (r_state == c_st_idle)
                r_push_cnt <= 16'd0;
            else if (w_push && (r_push_cnt != 16'hFFFF))
                r_push_cnt <= r_push_cnt + 16'd1;
            r_done <= w_pop & r_head[N_BITS];
        end
    end
`else
    assign w_entry = w_sel_data;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: if (en_i) w_state_nxt = c_st_run;
            c_st_run: begin
                if (!en_i)
                    w_state_nxt = c_st_idle;
`ifdef S_OUT_STREAM_LAST_EN
                else if (w_push && w_push_last)
                    w_state_nxt = c_st_done;
`endif
            end
`ifdef S_OUT_STREAM_LAST_EN
            c_st_done: if (!en_i) w_state_nxt = c_st_idle;
`endif
            default: w_state_nxt = c_st_idle;
        endcase
        if (flush_i)
            w_state_nxt = c_st_idle;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            r_state <= c_st_idle;
        else
            r_state <= w_state_nxt;
    end

    // Storage array carries no reset; occupancy is defined solely by r_count.
    always_ff @(posedge clk_i) begin
        if (w_push)
            r_mem[r_wr_ptr] <= w_entry;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            if (w_pop)
                r_rd_ptr <= w_rd_ptr_inc;
            if (w_push && !w_pop)
                r_count <= r_count + c_cnt_w'(1);
            else if (!w_push && w_pop)
                r_count <= r_count - c_cnt_w'(1);
            // Head register holds the oldest entry; a push into an empty
            // (or emptying) FIFO bypasses the array straight into it.
            if (w_pop && (r_count > c_cnt_w'(1)))
                r_head <= r_mem[w_rd_ptr_inc];
            else if (w_push && ((r_count == '0) || w_pop))
                r_head <= w_entry;
        end
    end

`ifndef SYNTHESIS
    a_sel_stable: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        (r_state == c_st_run) |=> ((r_state != c_st_run) || $stable(sel_i)));
`endif

endmodule
`default_nettype wire

// File: tb/tb_s_out_stream_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_s_out_stream_unit
//  Purpose  : Self-checking bench for s_out_stream_unit (vector table,
//             scoreboard runs and hand-written corner sequences).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_s_out_stream_unit;

    localparam int N_BITS   = 32;
    localparam int N_PE_SRC = 4;
    localparam int DEPTH    = 4;
    localparam int N_VEC    = 19;

    logic                       clk_i = 1'b0;
    logic                       rst_n_i;
    logic                       en_i;
    logic                       flush_i;
    logic [1:0]                 sel_i;
    logic [N_PE_SRC*N_BITS-1:0] pe_res_i;
    logic [N_PE_SRC-1:0]        pe_valid_i;
    logic                       pea_ready_o;
    logic [N_BITS-1:0]          stream_data_o;
    logic                       stream_valid_o;
    logic                       stream_ready_i;
`ifdef S_OUT_STREAM_LAST_EN
    logic [15:0]                len_i;
    logic                       last_o;
    logic                       done_o;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        en;
        logic        v;
        logic [31:0] d;
        logic        rdy;
        logic        e_pr;
        logic        e_sv;
        logic [31:0] e_d;
    } vec_t;

    vec_t vt [N_VEC];

    always #5 clk_i = ~clk_i;

    s_out_stream_unit #(
        .N_BITS   (N_BITS),
        .N_PE_SRC (N_PE_SRC),
        .DEPTH    (DEPTH)
    ) u_dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .en_i           (en_i),
        .flush_i        (flush_i),
        .sel_i          (sel_i),
        .pe_res_i       (pe_res_i),
        .pe_valid_i     (pe_valid_i),
        .pea_ready_o    (pea_ready_o),
        .stream_data_o  (stream_data_o),
        .stream_valid_o (stream_valid_o),
        .stream_ready_i (stream_ready_i)
`ifdef S_OUT_STREAM_LAST_EN
        ,
        .len_i          (len_i),
        .last_o         (last_o),
        .done_o         (done_o)
`endif
    );

    function automatic vec_t mk(input int en, input int v, input int d, input int rdy,
                                input int pr, input int sv, input int ed);
        vec_t r;
        r.en   = en[0];
        r.v    = v[0];
        r.d    = 32'(d);
        r.rdy  = rdy[0];
        r.e_pr = pr[0];
        r.e_sv = sv[0];
        r.e_d  = 32'(ed);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Unselected lanes carry the opposite valid and junk data.
    task automatic drive_pe(input logic v, input logic [31:0] d);
        for (int l = 0; l < N_PE_SRC; l++) begin
            if (l == int'(sel_i)) begin
                pe_valid_i[l]               = v;
                pe_res_i[l*N_BITS +: N_BITS] = d;
            end else begin
                pe_valid_i[l]               = ~v;
                pe_res_i[l*N_BITS +: N_BITS] = 32'hDEAD_0000 | 32'(l);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // PE-like source: holds its value until captured; expected order is the source order.
    task automatic run_sb(input int n_vals, input bit rnd);
        logic [31:0] vals  [$];
        logic [31:0] exp_q [$];
        int          idx;
        int          cyc;
        bit          presented;
        bit          pushing;
        idx       = 0;
        cyc       = 0;
        presented = 1'b0;
        for (int k = 0; k < n_vals; k++)
            vals.push_back(rnd ? $urandom : ((k == 4) ? 32'hA5 : 32'h20 + 32'(k)));
        while (((idx < n_vals) || (exp_q.size() != 0)) && (cyc < 200)) begin
            stream_ready_i = rnd ? ($urandom_range(0, 2) != 0) : (cyc >= 10);
            if (idx < n_vals) begin
                if (!presented) exp_q.push_back(vals[idx]);
                presented = 1'b1;
                drive_pe(1'b1, vals[idx]);
            end else begin
                drive_pe(1'b0, 32'h0);
            end
            #1;
            pushing = (idx < n_vals) && pea_ready_o;
            if (!rnd && (cyc == 7))
                check("sb stall pea_ready", pea_ready_o, 32'd0);
            if (stream_valid_o && stream_ready_i) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb extra element: got %0h expected none", stream_data_o);
                end else begin
                    check("sb data", stream_data_o, exp_q.pop_front());
                end
            end
            tick();
            if (pushing) begin
                idx++;
                presented = 1'b0;
            end
            cyc++;
        end
        check("sb drained", 32'((exp_q.size() == 0) && (idx == n_vals)), 32'd1);
        drive_pe(1'b0, 32'h0);
    endtask

    initial begin
        rst_n_i        = 1'b0;
        en_i           = 1'b0;
        flush_i        = 1'b0;
        sel_i          = 2'd2;
        stream_ready_i = 1'b0;
        pe_res_i       = '0;
        pe_valid_i     = '0;
`ifdef S_OUT_STREAM_LAST_EN
        len_i          = 16'd0;
`endif
        drive_pe(1'b0, 32'h0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;

        check("reset pea_ready", pea_ready_o, 32'd1);
        check("reset valid", stream_valid_o, 32'd0);
        check("reset data", stream_data_o, 32'd0);
`ifdef S_OUT_STREAM_LAST_EN
        check("reset last", last_o, 32'd0);
        check("reset done", done_o, 32'd0);
`endif

        // en, v, d, rdy | pea_ready, valid, data
        vt[0]  = mk(1, 0, 0,    1, 1, 0, 0);
        vt[1]  = mk(1, 1, 1,    1, 1, 0, 0);
        vt[2]  = mk(1, 1, 2,    1, 1, 1, 1);
        vt[3]  = mk(1, 1, 3,    1, 1, 1, 2);
        vt[4]  = mk(1, 1, 4,    1, 1, 1, 3);
        vt[5]  = mk(1, 0, 0,    1, 1, 1, 4);
        vt[6]  = mk(1, 0, 0,    1, 1, 0, 0);
        vt[7]  = mk(1, 1, 'h11, 0, 1, 0, 0);
        vt[8]  = mk(1, 1, 'h12, 0, 1, 1, 'h11);
        vt[9]  = mk(1, 1, 'h13, 0, 1, 1, 'h11);
        vt[10] = mk(1, 1, 'h14, 0, 1, 1, 'h11);
        vt[11] = mk(1, 1, 'h15, 0, 0, 1, 'h11);
        vt[12] = mk(1, 1, 'h15, 1, 0, 1, 'h11);
        vt[13] = mk(1, 1, 'h15, 0, 1, 1, 'h12);
        vt[14] = mk(1, 0, 0,    1, 0, 1, 'h12);
        vt[15] = mk(1, 0, 0,    1, 1, 1, 'h13);
        vt[16] = mk(1, 0, 0,    1, 1, 1, 'h14);
        vt[17] = mk(1, 0, 0,    1, 1, 1, 'h15);
        vt[18] = mk(1, 0, 0,    1, 1, 0, 0);

        for (int i = 0; i < N_VEC; i++) begin
            en_i           = vt[i].en;
            stream_ready_i = vt[i].rdy;
            drive_pe(vt[i].v, vt[i].d);
            #1;
            check($sformatf("vec%0d pea_ready", i), pea_ready_o, vt[i].e_pr);
            check($sformatf("vec%0d valid", i), stream_valid_o, vt[i].e_sv);
            if (vt[i].e_sv)
                check($sformatf("vec%0d data", i), stream_data_o, vt[i].e_d);
            @(posedge clk_i);
            #1;
        end

        // Stall with a held 0xA5, then release.
        run_sb(8, 1'b0);

        // Reselect lane 1 from IDLE, random back-pressure.
        en_i = 1'b0;
        tick();
        sel_i = 2'd1;
        en_i  = 1'b1;
        drive_pe(1'b0, 32'h0);
        tick();
        run_sb(20, 1'b1);

        // Flush together with push and pop on a 3-deep queue.
        stream_ready_i = 1'b0;
        drive_pe(1'b1, 32'h31); tick();
        drive_pe(1'b1, 32'h32); tick();
        drive_pe(1'b1, 32'h33); tick();
        check("flush pre valid", stream_valid_o, 32'd1);
        check("flush pre data", stream_data_o, 32'h31);
        flush_i        = 1'b1;
        stream_ready_i = 1'b1;
        drive_pe(1'b1, 32'h34);
        tick();
        flush_i        = 1'b0;
        stream_ready_i = 1'b0;
        check("flush valid", stream_valid_o, 32'd0);
        check("flush pea_ready", pea_ready_o, 32'd1);
        drive_pe(1'b1, 32'h35);
        tick();
        check("flush idle no capture", stream_valid_o, 32'd0);
        drive_pe(1'b1, 32'h36);
        tick();
        drive_pe(1'b0, 32'h0);
        tick();
        check("post flush valid", stream_valid_o, 32'd1);
        check("post flush data", stream_data_o, 32'h36);
        stream_ready_i = 1'b1;
        tick();
        check("post flush drained", stream_valid_o, 32'd0);

`ifdef S_OUT_STREAM_LAST_EN
        en_i = 1'b0;
        tick();
        len_i = 16'd3;
        en_i  = 1'b1;
        tick();
        drive_pe(1'b1, 32'd7);
        #1;
        check("len valid0", stream_valid_o, 32'd0);
        tick();
        drive_pe(1'b1, 32'd8);
        check("len data7", stream_data_o, 32'd7);
        check("len last7", last_o, 32'd0);
        tick();
        drive_pe(1'b1, 32'd9);
        check("len data8", stream_data_o, 32'd8);
        check("len last8", last_o, 32'd0);
        tick();
        drive_pe(1'b1, 32'd10);
        check("len data9", stream_data_o, 32'd9);
        check("len last9", last_o, 32'd1);
        check("len pea_ready done", pea_ready_o, 32'd1);
        check("len done early", done_o, 32'd0);
        tick();
        check("len no 10", stream_valid_o, 32'd0);
        check("len done pulse", done_o, 32'd1);
        check("len pea_ready done2", pea_ready_o, 32'd1);
        tick();
        check("len done once", done_o, 32'd0);
        check("len still empty", stream_valid_o, 32'd0);
        en_i  = 1'b0;
        len_i = 16'd0;
        drive_pe(1'b0, 32'h0);
        tick();
        en_i = 1'b1;
        tick();
`endif

        // Asynchronous reset with two entries queued.
        stream_ready_i = 1'b0;
        drive_pe(1'b1, 32'h41); tick();
        drive_pe(1'b1, 32'h42); tick();
        drive_pe(1'b0, 32'h0);
        check("rst pre valid", stream_valid_o, 32'd1);
        #2;
        rst_n_i = 1'b0;
        #1;
        check("async rst valid", stream_valid_o, 32'd0);
        check("async rst data", stream_data_o, 32'd0);
        check("async rst pea_ready", pea_ready_o, 32'd1);
`ifdef S_OUT_STREAM_LAST_EN
        check("async rst last", last_o, 32'd0);
        check("async rst done", done_o, 32'd0);
`endif
        tick();
        rst_n_i = 1'b1;
        tick();
        check("post rst valid", stream_valid_o, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
